pcie_tx_axis_to_avst: RTL

PCIE_TX_AXIS_TO_AVST -- requirements
Module: pcie_tx_axis_to_avst

---
 rtl/pcie_tx_axis_to_avst.sv | 107 ++++++++++
 1 files changed

// File: rtl/pcie_tx_axis_to_avst.sv
// pcie_tx_axis_to_avst: buffers AXI-stream TLP beats and replays them onto an Avalon-ST TX
// port that grants one beat slot READY_LATENCY cycles after each ready, with framing checks.
module pcie_tx_axis_to_avst #(
  parameter int DATA_W        = 256,
  parameter int HDR_W         = 128,
  parameter int READY_LATENCY = 3,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic              avl_clk,
  input  logic              avl_rst_n,
  input  logic              axis_tx_tvalid,
  output logic              axis_tx_tready,
  input  logic              axis_tx_tsop,
  input  logic              axis_tx_teop,
  input  logic [HDR_W-1:0]  axis_tx_thdr,
  input  logic [DATA_W-1:0] axis_tx_tdata,
  input  logic              avl_tx_ready,
  output logic              avl_tx_valid,
  output logic              avl_tx_sop,
  output logic              avl_tx_eop,
  output logic [HDR_W-1:0]  avl_tx_hdr,
  output logic [DATA_W-1:0] avl_tx_data,
  output logic              tx_err_framing,
  output logic [31:0]       tx_tlp_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = DATA_W + HDR_W + 2;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t            r_state, w_state_nxt;
  logic [BW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_cnt, w_cnt_nxt;
  logic              r_tready, r_valid, r_sop, r_eop, r_err;
  logic [HDR_W-1:0]  r_hdr;
  logic [DATA_W-1:0] r_data;
  logic [31:0]       r_tlp_cnt;
  logic              w_acc, w_push, w_pop, w_err, w_perm;

  // w_perm: this edge loads the output register for the cycle whose slot was granted
  if (READY_LATENCY == 1) begin : g_rl1
    assign w_perm = avl_tx_ready;
  end else begin : g_rln
    logic [READY_LATENCY-2:0] r_hist;
    logic [READY_LATENCY-1:0] w_rdy;
    assign w_rdy  = {r_hist, avl_tx_ready};
    assign w_perm = w_rdy[READY_LATENCY-1];
    always_ff @(posedge avl_clk or negedge avl_rst_n)
      if (!avl_rst_n) r_hist <= '0;
      else r_hist <= w_rdy[READY_LATENCY-2:0];
  end

  assign w_acc = axis_tx_tvalid && r_tready;
  assign w_pop = w_perm && (r_cnt != '0);

  // a sop always opens a TLP; a non-sop beat is only legal inside one
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_err       = 1'b0;
    if (w_acc) begin
      w_push = axis_tx_tsop || (r_state == IN_PKT);
      w_err  = axis_tx_tsop == (r_state == IN_PKT);
      if (w_push) w_state_nxt = axis_tx_teop ? IDLE : IN_PKT;
    end
  end

  assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge avl_clk or negedge avl_rst_n)
    if (!avl_rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;

  always_ff @(posedge avl_clk)
    if (w_push) r_mem[r_wp] <= {axis_tx_tsop, axis_tx_teop, axis_tx_thdr, axis_tx_tdata};

  always_ff @(posedge avl_clk or negedge avl_rst_n)
    if (!avl_rst_n) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_tready  <= 1'b0;
      r_valid   <= 1'b0;
      {r_sop, r_eop, r_hdr, r_data} <= '0;
      r_err     <= 1'b0;
      r_tlp_cnt <= '0;
    end else begin
      r_wp      <= r_wp + AW'(w_push);
      r_rp      <= r_rp + AW'(w_pop);
      r_cnt     <= w_cnt_nxt;
      r_tready  <= w_cnt_nxt < (AW+1)'(FIFO_DEPTH);
      r_valid   <= w_pop;
      {r_sop, r_eop, r_hdr, r_data} <= w_pop ? r_mem[r_rp] : '0;
      r_err     <= r_err || w_err;
      r_tlp_cnt <= r_tlp_cnt + 32'(r_valid && r_eop);
    end

  assign axis_tx_tready = r_tready;
  assign avl_tx_valid   = r_valid;
  assign avl_tx_sop     = r_sop;
  assign avl_tx_eop     = r_eop;
  assign avl_tx_hdr     = r_hdr;
  assign avl_tx_data    = r_data;
  assign tx_err_framing = r_err;
  assign tx_tlp_cnt     = r_tlp_cnt;
endmodule
